mvm_weight_loader: RTL and testbench

Sequences the loading of one MVM problem into the mesh: reads 1024-bit weight lines from a local weight memory and emits AXIS write-RF beats for every target router, then optionally emits one input-vector beat. It sits between the host command logic and the `AXIS_S_*` port of `mvm_top`, in the same clock domain. It replaces hand-driven load sequences with one command.

---
 rtl/mvm_loader_pkg.sv | 34 +++
 rtl/mvm_loader_tuser_enc.sv | 38 +++
 rtl/mvm_weight_loader.sv | 249 ++++++++++++++++++++++++
 tb/tb_mvm_weight_loader.sv | 314 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mvm_loader_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : mvm_loader_pkg                                          |
// | Description : Shared types and TUSER field layout for the MVM weight |
// |               loader (state encoding, op codes, field offsets).      |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
package mvm_loader_pkg;

  // Sequencer states
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_RD    = 3'd1,
    ST_LAT   = 3'd2,
    ST_SEND  = 3'd3,
    ST_VRD   = 3'd4,
    ST_VLAT  = 3'd5,
    ST_VSEND = 3'd6,
    ST_FIN   = 3'd7
  } state_t;

  // TUSER op codes understood by the mesh routers
  localparam logic [1:0] OP_WRITE_RF  = 2'b11;
  localparam logic [1:0] OP_INPUT_VEC = 2'b10;

  // TUSER field layout
  localparam int RF_ADDR_LSB = 0;
  localparam int RF_ADDR_W   = 9;
  localparam int OP_LSB      = 9;
  localparam int OP_W        = 2;
  localparam int RF_SEL_LSB  = 11;

endpackage : mvm_loader_pkg
`default_nettype wire

// File: rtl/mvm_loader_tuser_enc.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : mvm_loader_tuser_enc                                    |
// | Description : Combinational TUSER builder: packs RF address, op code |
// |               and a one-hot RF select derived from the line index.   |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module mvm_loader_tuser_enc
  import mvm_loader_pkg::*;
#(
  parameter int USERW = 75,
  parameter int LINEW = 6
) (
  input  logic [OP_W-1:0]      op,
  input  logic [RF_ADDR_W-1:0] rf_addr,
  input  logic [LINEW-1:0]     line,
  input  logic                 sel_en,
  output logic [USERW-1:0]     tuser
);

  localparam int RFSELW = USERW - RF_SEL_LSB;

  logic [RFSELW-1:0] rf_sel;

  // Assemble the sideband word; the RF select is empty for vector beats
  always_comb begin
    rf_sel = '0;
    if (sel_en) begin
      rf_sel[line] = 1'b1;
    end
    tuser                              = '0;
    tuser[RF_ADDR_LSB +: RF_ADDR_W]    = rf_addr;
    tuser[OP_LSB +: OP_W]              = op;
    tuser[RF_SEL_LSB +: RFSELW]        = rf_sel;
  end

endmodule : mvm_loader_tuser_enc
`default_nettype wire

// File: rtl/mvm_weight_loader.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : mvm_weight_loader                                       |
// | Description : Loads one MVM problem into the mesh: streams every     |
// |               weight line of every target router as an AXIS write-RF |
// |               beat, then optionally one input-vector beat.           |
// |               Optional statistics: define MVM_LOADER_STATS_EN.       |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module mvm_weight_loader
  import mvm_loader_pkg::*;
#(
  parameter int DATAW  = 512,
  parameter int DESTW  = 12,
  parameter int USERW  = 75,
  parameter int IDW    = 32,
  parameter int NUM_RF = 64,
  parameter int MEM_AW = 7
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 CMD_VALID,
  output logic                 CMD_READY,
  input  logic [DESTW-1:0]     CMD_BASE_DEST,
  input  logic [DESTW-1:0]     CMD_NUM_ROUTERS,
  input  logic [8:0]           CMD_RF_ADDR,
  input  logic                 CMD_LOAD_VEC,
  input  logic [DESTW-1:0]     CMD_VEC_DEST,
  output logic                 MEM_RD_EN,
  output logic [MEM_AW-1:0]    MEM_RD_ADDR,
  input  logic [2*DATAW-1:0]   MEM_RD_DATA,
  output logic                 AXIS_M_TVALID,
  input  logic                 AXIS_M_TREADY,
  output logic [DATAW-1:0]     AXIS_M_TDATA,
  output logic                 AXIS_M_TLAST,
  output logic [IDW-1:0]       AXIS_M_TID,
  output logic [USERW-1:0]     AXIS_M_TUSER,
  output logic [DESTW-1:0]     AXIS_M_TDEST,
  output logic                 DONE
`ifdef MVM_LOADER_STATS_EN
  ,
  output logic [31:0]          STAT_BEATS,
  output logic [31:0]          STAT_STALLS
`endif
);

  localparam int LINEW = (NUM_RF > 1) ? $clog2(NUM_RF) : 1;

  state_t state;
  state_t next_state;

  logic [DESTW-1:0]     cmd_base_dest;
  logic [DESTW-1:0]     cmd_num_routers;
  logic [8:0]           cmd_rf_addr;
  logic                 cmd_load_vec;
  logic [DESTW-1:0]     cmd_vec_dest;

  logic [DESTW-1:0]     rtr_cnt;
  logic [LINEW-1:0]     line_cnt;

  logic                 cmd_accept;
  logic                 handshake;
  logic                 line_last;
  logic                 rtr_last;

  logic                 vec_phase;
  logic [OP_W-1:0]      enc_op;
  logic [RF_ADDR_W-1:0] enc_rf_addr;
  logic [USERW-1:0]     enc_tuser;

  assign cmd_accept = (state == ST_IDLE) && CMD_VALID;
  assign handshake  = AXIS_M_TVALID && AXIS_M_TREADY;
  assign line_last  = (line_cnt == LINEW'(NUM_RF - 1));
  assign rtr_last   = (rtr_cnt == (cmd_num_routers - DESTW'(1)));
  assign AXIS_M_TID = '0;

  // Vector beats carry a different op, no RF address and no RF select
  assign vec_phase   = (state == ST_VLAT);
  assign enc_op      = vec_phase ? OP_INPUT_VEC : OP_WRITE_RF;
  assign enc_rf_addr = vec_phase ? '0 : cmd_rf_addr;

  mvm_loader_tuser_enc #(
    .USERW (USERW),
    .LINEW (LINEW)
  ) u_tuser_enc (
    .op      (enc_op),
    .rf_addr (enc_rf_addr),
    .line    (line_cnt),
    .sel_en  (!vec_phase),
    .tuser   (enc_tuser)
  );

  // State register
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state <= ST_IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state decode plus memory-read, ready and done strobes
  always_comb begin
    next_state  = state;
    CMD_READY   = 1'b0;
    MEM_RD_EN   = 1'b0;
    MEM_RD_ADDR = '0;
    DONE        = 1'b0;
    case (state)
      ST_IDLE: begin
        CMD_READY = 1'b1;
        if (CMD_VALID) begin
          if (CMD_NUM_ROUTERS != '0) begin
            next_state = ST_RD;
          end else if (CMD_LOAD_VEC) begin
            next_state = ST_VRD;
          end else begin
            next_state = ST_FIN;
          end
        end
      end
      ST_RD: begin
        MEM_RD_EN   = 1'b1;
        MEM_RD_ADDR = MEM_AW'(line_cnt);
        next_state  = ST_LAT;
      end
      ST_LAT: begin
        next_state = ST_SEND;
      end
      ST_SEND: begin
        if (handshake) begin
          if (!line_last) begin
            next_state = ST_RD;
          end else if (!rtr_last) begin
            next_state = ST_RD;
          end else if (cmd_load_vec) begin
            next_state = ST_VRD;
          end else begin
            next_state = ST_FIN;
          end
        end
      end
      ST_VRD: begin
        MEM_RD_EN   = 1'b1;
        MEM_RD_ADDR = MEM_AW'(NUM_RF);
        next_state  = ST_VLAT;
      end
      ST_VLAT: begin
        next_state = ST_VSEND;
      end
      ST_VSEND: begin
        if (handshake) begin
          next_state = ST_FIN;
        end
      end
      ST_FIN: begin
        DONE       = 1'b1;
        next_state = ST_IDLE;
      end
      default: begin
        next_state = ST_IDLE;
      end
    endcase
  end

  // Command capture; fields stay frozen for the whole sequence
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      cmd_base_dest   <= '0;
      cmd_num_routers <= '0;
      cmd_rf_addr     <= '0;
      cmd_load_vec    <= 1'b0;
      cmd_vec_dest    <= '0;
    end else if (cmd_accept) begin
      cmd_base_dest   <= CMD_BASE_DEST;
      cmd_num_routers <= CMD_NUM_ROUTERS;
      cmd_rf_addr     <= CMD_RF_ADDR;
      cmd_load_vec    <= CMD_LOAD_VEC;
      cmd_vec_dest    <= CMD_VEC_DEST;
    end
  end

  // Router / line counters advance on each accepted weight beat
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      rtr_cnt  <= '0;
      line_cnt <= '0;
    end else if (cmd_accept) begin
      rtr_cnt  <= '0;
      line_cnt <= '0;
    end else if ((state == ST_SEND) && handshake) begin
      if (line_last) begin
        line_cnt <= '0;
        rtr_cnt  <= rtr_cnt + DESTW'(1);
      end else begin
        line_cnt <= line_cnt + LINEW'(1);
      end
    end
  end

  // AXIS output registers: loaded from the read data in the latency
  // state, held until the beat is accepted
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      AXIS_M_TVALID <= 1'b0;
      AXIS_M_TDATA  <= '0;
      AXIS_M_TUSER  <= '0;
      AXIS_M_TDEST  <= '0;
      AXIS_M_TLAST  <= 1'b0;
    end else if (state == ST_LAT) begin
      AXIS_M_TVALID <= 1'b1;
      AXIS_M_TDATA  <= rtr_cnt[0] ? MEM_RD_DATA[DATAW-1:0]
                                  : MEM_RD_DATA[2*DATAW-1:DATAW];
      AXIS_M_TUSER  <= enc_tuser;
      AXIS_M_TDEST  <= cmd_base_dest + rtr_cnt;
      AXIS_M_TLAST  <= 1'b1;
    end else if (state == ST_VLAT) begin
      AXIS_M_TVALID <= 1'b1;
      AXIS_M_TDATA  <= MEM_RD_DATA[DATAW-1:0];
      AXIS_M_TUSER  <= enc_tuser;
      AXIS_M_TDEST  <= cmd_vec_dest;
      AXIS_M_TLAST  <= 1'b1;
    end else if (handshake) begin
      AXIS_M_TVALID <= 1'b0;
    end
  end

`ifdef MVM_LOADER_STATS_EN
  // Saturating beat and stall counters, restarted with each command
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      STAT_BEATS  <= '0;
      STAT_STALLS <= '0;
    end else if (cmd_accept) begin
      STAT_BEATS  <= '0;
      STAT_STALLS <= '0;
    end else begin
      if (handshake && (STAT_BEATS != '1)) begin
        STAT_BEATS <= STAT_BEATS + 32'd1;
      end
      if (AXIS_M_TVALID && !AXIS_M_TREADY && (STAT_STALLS != '1)) begin
        STAT_STALLS <= STAT_STALLS + 32'd1;
      end
    end
  end
`endif

endmodule : mvm_weight_loader
`default_nettype wire

// File: tb/tb_mvm_weight_loader.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : tb_mvm_weight_loader                                    |
// | Description : Directed self-checking bench for mvm_weight_loader.    |
// |               Honours MVM_LOADER_STATS_EN when defined.              |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module tb_mvm_weight_loader;

  localparam int DATAW  = 512;
  localparam int DESTW  = 12;
  localparam int USERW  = 75;
  localparam int IDW    = 32;
  localparam int NUM_RF = 64;
  localparam int MEM_AW = 7;

  logic                 CLK = 1'b0;
  logic                 RST = 1'b1;
  logic                 CMD_VALID = 1'b0;
  logic                 CMD_READY;
  logic [DESTW-1:0]     CMD_BASE_DEST = '0;
  logic [DESTW-1:0]     CMD_NUM_ROUTERS = '0;
  logic [8:0]           CMD_RF_ADDR = '0;
  logic                 CMD_LOAD_VEC = 1'b0;
  logic [DESTW-1:0]     CMD_VEC_DEST = '0;
  logic                 MEM_RD_EN;
  logic [MEM_AW-1:0]    MEM_RD_ADDR;
  logic [2*DATAW-1:0]   MEM_RD_DATA = '0;
  logic                 AXIS_M_TVALID;
  logic                 AXIS_M_TREADY = 1'b1;
  logic [DATAW-1:0]     AXIS_M_TDATA;
  logic                 AXIS_M_TLAST;
  logic [IDW-1:0]       AXIS_M_TID;
  logic [USERW-1:0]     AXIS_M_TUSER;
  logic [DESTW-1:0]     AXIS_M_TDEST;
  logic                 DONE;
`ifdef MVM_LOADER_STATS_EN
  logic [31:0]          STAT_BEATS;
  logic [31:0]          STAT_STALLS;
`endif

  mvm_weight_loader #(
    .DATAW (DATAW), .DESTW (DESTW), .USERW (USERW),
    .IDW (IDW), .NUM_RF (NUM_RF), .MEM_AW (MEM_AW)
  ) dut (
    .CLK             (CLK),
    .RST             (RST),
    .CMD_VALID       (CMD_VALID),
    .CMD_READY       (CMD_READY),
    .CMD_BASE_DEST   (CMD_BASE_DEST),
    .CMD_NUM_ROUTERS (CMD_NUM_ROUTERS),
    .CMD_RF_ADDR     (CMD_RF_ADDR),
    .CMD_LOAD_VEC    (CMD_LOAD_VEC),
    .CMD_VEC_DEST    (CMD_VEC_DEST),
    .MEM_RD_EN       (MEM_RD_EN),
    .MEM_RD_ADDR     (MEM_RD_ADDR),
    .MEM_RD_DATA     (MEM_RD_DATA),
    .AXIS_M_TVALID   (AXIS_M_TVALID),
    .AXIS_M_TREADY   (AXIS_M_TREADY),
    .AXIS_M_TDATA    (AXIS_M_TDATA),
    .AXIS_M_TLAST    (AXIS_M_TLAST),
    .AXIS_M_TID      (AXIS_M_TID),
    .AXIS_M_TUSER    (AXIS_M_TUSER),
    .AXIS_M_TDEST    (AXIS_M_TDEST),
    .DONE            (DONE)
`ifdef MVM_LOADER_STATS_EN
    ,
    .STAT_BEATS      (STAT_BEATS),
    .STAT_STALLS     (STAT_STALLS)
`endif
  );

  always #5 CLK = ~CLK;

  // Weight memory: each 32-bit chunk tags its half, address and position
  function automatic logic [2*DATAW-1:0] mem_word(input int a);
    logic [2*DATAW-1:0] w;
    for (int j = 0; j < 32; j++) begin
      w[j*32 +: 32] = {((j >= 16) ? 8'hB1 : 8'hA2), 8'(a), 8'(j), 8'h5A};
    end
    return w;
  endfunction

  logic [2*DATAW-1:0] mem [0:127];

  // Synchronous read, data one cycle after the enable
  always @(posedge CLK) begin
    if (MEM_RD_EN) MEM_RD_DATA <= mem[MEM_RD_ADDR];
  end

  int n_cmp = 0;
  int n_err = 0;

  task automatic check_val(input string tag, input logic [511:0] got,
                           input logic [511:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Expected command and observation state
  int               exp_base, exp_nr, exp_rfa, exp_vec, exp_vdest;
  int               beat_cnt, done_cnt, last_hs, cyc;
  logic             stalled_prev = 1'b0;
  logic [DATAW-1:0] hold_data;
  logic [USERW-1:0] hold_user;
  logic [DESTW-1:0] hold_dest;

  task automatic score();
    int r, i, nw;
    logic [2*DATAW-1:0] w;
    logic [DATAW-1:0]   ed;
    logic [USERW-1:0]   eu;
    logic [DESTW-1:0]   edst;
    nw = exp_nr * NUM_RF;
    eu = '0;
    if (beat_cnt < nw) begin
      r = beat_cnt / NUM_RF;
      i = beat_cnt % NUM_RF;
      w = mem_word(i);
      ed = (r % 2 == 0) ? w[2*DATAW-1:DATAW] : w[DATAW-1:0];
      edst = DESTW'(exp_base + r);
      eu[8:0] = 9'(exp_rfa);
      eu[10:9] = 2'b11;
      eu[11+i] = 1'b1;
    end else if (exp_vec != 0 && beat_cnt == nw) begin
      w = mem_word(NUM_RF);
      ed = w[DATAW-1:0];
      edst = DESTW'(exp_vdest);
      eu[10:9] = 2'b10;
    end else begin
      check_val("extra_beat", beat_cnt + 1, nw + exp_vec);
      return;
    end
    check_val("tdata", AXIS_M_TDATA, ed);
    check_val("tuser", AXIS_M_TUSER, eu);
    check_val("tdest", AXIS_M_TDEST, edst);
    check_val("tlast", AXIS_M_TLAST, 1);
    check_val("tid", AXIS_M_TID, 0);
  endtask

  // Observation at the falling edge: stall stability, DONE, handshakes
  task automatic mon();
    if (RST) begin
      stalled_prev = 1'b0;
      return;
    end
    if (stalled_prev) begin
      check_val("hold_valid", AXIS_M_TVALID, 1);
      check_val("hold_data", AXIS_M_TDATA, hold_data);
      check_val("hold_user", AXIS_M_TUSER, hold_user);
      check_val("hold_dest", AXIS_M_TDEST, hold_dest);
    end
    if (DONE) begin
      done_cnt++;
      if (beat_cnt > 0) check_val("done_lat", cyc, last_hs + 1);
    end
    if (AXIS_M_TVALID && AXIS_M_TREADY) begin
      score();
      beat_cnt++;
      last_hs = cyc;
    end
    stalled_prev = AXIS_M_TVALID && !AXIS_M_TREADY;
    hold_data = AXIS_M_TDATA;
    hold_user = AXIS_M_TUSER;
    hold_dest = AXIS_M_TDEST;
  endtask

  task automatic tick();
    @(negedge CLK);
    mon();
    @(posedge CLK);
    #1;
    cyc++;
  endtask

  task automatic start_cmd(input int base, input int nr, input int rfa,
                           input int vec, input int vdest);
    int n;
    exp_base = base; exp_nr = nr; exp_rfa = rfa;
    exp_vec = vec; exp_vdest = vdest;
    beat_cnt = 0; done_cnt = 0;
    AXIS_M_TREADY = 1'b1;
    n = 0;
    while (!CMD_READY && n < 50) begin
      tick();
      n++;
    end
    check_val("cmd_ready", CMD_READY, 1);
    CMD_BASE_DEST   = DESTW'(base);
    CMD_NUM_ROUTERS = DESTW'(nr);
    CMD_RF_ADDR     = 9'(rfa);
    CMD_LOAD_VEC    = (vec != 0);
    CMD_VEC_DEST    = DESTW'(vdest);
    CMD_VALID       = 1'b1;
    tick();
    CMD_VALID = 1'b0;
    if (nr != 0 || vec != 0) begin
      check_val("rd_en_k1", MEM_RD_EN, 1);
      check_val("tvalid_k1", AXIS_M_TVALID, 0);
      tick();
      check_val("tvalid_k2", AXIS_M_TVALID, 0);
      tick();
      check_val("tvalid_k3", AXIS_M_TVALID, 1);
    end
  endtask

  task automatic finish_cmd(input int toggle, input int poke);
    int n;
    int beats_done;
    n = 0;
    while (done_cnt == 0 && n < 3000) begin
      if (toggle != 0) AXIS_M_TREADY = ~AXIS_M_TREADY;
      CMD_VALID = (poke != 0 && n == 20);
      CMD_BASE_DEST = (poke != 0 && n == 20) ? 12'h555 : DESTW'(exp_base);
      tick();
      n++;
    end
    CMD_VALID = 1'b0;
    AXIS_M_TREADY = 1'b1;
    check_val("done_seen", done_cnt, 1);
    check_val("ready_after_done", CMD_READY, 1);
    check_val("done_pulse", DONE, 0);
    check_val("beat_count", beat_cnt, exp_nr * NUM_RF + exp_vec);
`ifdef MVM_LOADER_STATS_EN
    check_val("stat_beats", STAT_BEATS, beat_cnt);
`endif
    beats_done = beat_cnt;
    repeat (8) tick();
    check_val("no_restart_beats", beat_cnt, beats_done);
    check_val("no_restart_done", done_cnt, 1);
    check_val("idle_tvalid", AXIS_M_TVALID, 0);
  endtask

  initial begin
    int n;
    for (int a = 0; a < 128; a++) mem[a] = mem_word(a);
    cyc = 0; last_hs = 0; beat_cnt = 0; done_cnt = 0;

    // Reset state
    repeat (3) @(posedge CLK);
    #1;
    check_val("rst_tvalid", AXIS_M_TVALID, 0);
    check_val("rst_rd_en", MEM_RD_EN, 0);
    check_val("rst_done", DONE, 0);
    check_val("rst_tdata", AXIS_M_TDATA, 0);
    check_val("rst_tuser", AXIS_M_TUSER, 0);
    check_val("rst_tdest", AXIS_M_TDEST, 0);
    check_val("rst_tlast", AXIS_M_TLAST, 0);
    check_val("rst_tid", AXIS_M_TID, 0);
    RST = 1'b0;
    tick();
    check_val("rst_cmd_ready", CMD_READY, 1);

    // Two routers, always ready
    start_cmd(12'h001, 2, 9'h015, 0, 0);
    finish_cmd(0, 0);

    // One router with back-pressure every other cycle
    start_cmd(12'h010, 1, 9'h1FF, 0, 0);
    finish_cmd(1, 0);

    // Vector only
    start_cmd(12'h000, 0, 9'h000, 1, 12'h001);
    finish_cmd(0, 0);

    // Destination wrap, vector after weights, command poked while busy
    start_cmd(12'hFFF, 2, 9'h0A5, 1, 12'h0AB);
    finish_cmd(0, 1);

    // Nothing to load: DONE only
    start_cmd(12'h123, 0, 9'h000, 0, 0);
    finish_cmd(0, 0);

    // Reset while beat 10 is stalled on the bus
    start_cmd(12'h040, 1, 9'h00A, 1, 12'h0AA);
    n = 0;
    while (beat_cnt < 10 && n < 200) begin
      tick();
      n++;
    end
    AXIS_M_TREADY = 1'b0;
    n = 0;
    while (!AXIS_M_TVALID && n < 20) begin
      tick();
      n++;
    end
    check_val("pre_rst_beats", beat_cnt, 10);
    check_val("pre_rst_tvalid", AXIS_M_TVALID, 1);
    @(negedge CLK);
    mon();
    #2;
    RST = 1'b1;
    #1;
    check_val("async_tvalid", AXIS_M_TVALID, 0);
    check_val("async_rd_en", MEM_RD_EN, 0);
    check_val("async_done", DONE, 0);
    stalled_prev = 1'b0;
    repeat (2) @(posedge CLK);
    #1;
    RST = 1'b0;
    AXIS_M_TREADY = 1'b1;
    check_val("rst_no_done", done_cnt, 0);
    start_cmd(12'h020, 1, 9'h003, 0, 0);
    finish_cmd(0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule : tb_mvm_weight_loader
`default_nettype wire
